// File: rtl/ama_riscv_wb_arbiter.sv
// Writeback arbiter: merges in-order pipe writebacks with queued long-latency
// results onto the single RF write port, and tracks pending long-latency rds.
module ama_riscv_wb_arbiter #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          pipe_we,
    input  logic [4:0]                    pipe_rd,
    input  logic [31:0]                   pipe_data,
    input  logic                          ll_iss_valid,
    input  logic [4:0]                    ll_iss_rd,
    output logic                          ll_iss_ready,
    input  logic                          ll_valid,
    output logic                          ll_ready,
    input  logic [4:0]                    ll_rd,
    input  logic [31:0]                   ll_data,
    output logic                          rf_we,
    output logic [4:0]                    rf_addr_d,
    output logic [31:0]                   rf_data_d,
    input  logic [4:0]                    rs1_addr,
    input  logic [4:0]                    rs2_addr,
    output logic                          rs1_busy,
    output logic                          rs2_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ll_res_t;

    ll_res_t       fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   pending;
    logic [31:0]   pending_nxt;
    logic          rf_src_ll;
    logic          push;
    logic          pop;
    logic          pipe_wr;
    logic          iss_set;

    assign ll_ready     = (fifo_cnt != (PW+1)'(FIFO_DEPTH));
    assign ll_iss_ready = (ll_iss_rd == 5'd0) || !pending[ll_iss_rd];
    assign rs1_busy     = (rs1_addr != 5'd0) && pending[rs1_addr];
    assign rs2_busy     = (rs2_addr != 5'd0) && pending[rs2_addr];

    // Results for x0 are handshaken but never stored
    assign push    = ll_valid && ll_ready && (ll_rd != 5'd0);
    assign pipe_wr = pipe_we && (pipe_rd != 5'd0);
    assign pop     = !pipe_wr && (fifo_cnt != '0);
    assign iss_set = ll_iss_valid && ll_iss_ready && (ll_iss_rd != 5'd0);

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= '{rd: ll_rd, data: ll_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PW+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PW+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we     <= 1'b0;
            rf_addr_d <= '0;
            rf_data_d <= '0;
            rf_src_ll <= 1'b0;
        end else if (pipe_wr) begin
            rf_we     <= 1'b1;
            rf_addr_d <= pipe_rd;
            rf_data_d <= pipe_data;
            rf_src_ll <= 1'b0;
        end else if (pop) begin
            rf_we     <= 1'b1;
            rf_addr_d <= fifo_mem[rd_ptr].rd;
            rf_data_d <= fifo_mem[rd_ptr].data;
            rf_src_ll <= 1'b1;
        end else begin
            rf_we     <= 1'b0;
        end
    end

    // Clear happens on the same edge the RF captures the value; a same-rd
    // issue that cycle is already refused because the bit is still set.
    always_comb begin
        pending_nxt = pending;
        if (rf_we && rf_src_ll) pending_nxt[rf_addr_d] = 1'b0;
        if (iss_set)            pending_nxt[ll_iss_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= pending_nxt;
    end

endmodule

// File: tb/tb_ama_riscv_wb_arbiter.sv
// Bench for ama_riscv_wb_arbiter: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_ama_riscv_wb_arbiter;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_we, ll_iss_valid, ll_valid;
    logic [4:0]  pipe_rd, ll_iss_rd, ll_rd, rs1_addr, rs2_addr;
    logic [31:0] pipe_data, ll_data;
    logic        ll_iss_ready, ll_ready, rf_we, rs1_busy, rs2_busy;
    logic [4:0]  rf_addr_d;
    logic [31:0] rf_data_d;
    logic [$clog2(D):0] fifo_cnt;

    ama_riscv_wb_arbiter #(.FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .ll_iss_valid(ll_iss_valid), .ll_iss_rd(ll_iss_rd), .ll_iss_ready(ll_iss_ready),
        .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_data(ll_data),
        .rf_we(rf_we), .rf_addr_d(rf_addr_d), .rf_data_d(rf_data_d),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .fifo_cnt(fifo_cnt)
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;
    bit chk_en = 1'b0;

    // Reference model: set of pending rds, result queue, RF write port
    logic [31:0] m_pend;
    logic [36:0] m_q[$];
    logic        m_we, m_src;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          infl[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_q.delete(); infl.delete();
        m_we = 1'b0; m_src = 1'b0; m_addr = '0; m_data = '0;
    endtask

    task automatic model_edge();
        logic        iss_ok, acc;
        logic [36:0] e;
        if (!rst_n) return;
        assert (!(pipe_we && pipe_rd != 0 && m_pend[pipe_rd]))
            else $error("illegal stimulus: pipe write to pending x%0d", pipe_rd);
        assert (!(ll_valid && ll_rd != 0 && !m_pend[ll_rd]))
            else $error("illegal stimulus: result to idle x%0d", ll_rd);
        iss_ok = ll_iss_valid && (ll_iss_rd == 0 || !m_pend[ll_iss_rd]);
        acc    = ll_valid && (m_q.size() < D);
        if (m_we && m_src) m_pend[m_addr] = 1'b0;
        if (iss_ok && ll_iss_rd != 0) begin
            m_pend[ll_iss_rd] = 1'b1;
            infl.push_back(int'(ll_iss_rd));
        end
        if (pipe_we && pipe_rd != 0) begin
            m_we = 1'b1; m_src = 1'b0; m_addr = pipe_rd; m_data = pipe_data;
        end else if (m_q.size() > 0) begin
            e = m_q.pop_front();
            m_we = 1'b1; m_src = 1'b1; m_addr = e[36:32]; m_data = e[31:0];
        end else begin
            m_we = 1'b0;
        end
        if (acc && ll_rd != 0) begin
            m_q.push_back({ll_rd, ll_data});
            foreach (infl[i]) if (infl[i] == int'(ll_rd)) begin infl.delete(i); break; end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        pipe_we = 1'b0; ll_iss_valid = 1'b0; ll_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("rf_we", rf_we, m_we);
            chk("rf_addr_d", rf_addr_d, m_addr);
            chk("rf_data_d", rf_data_d, m_data);
            chk("fifo_cnt", fifo_cnt, m_q.size());
            chk("ll_ready", ll_ready, m_q.size() != D);
            chk("ll_iss_ready", ll_iss_ready, ll_iss_rd == 0 || !m_pend[ll_iss_rd]);
            chk("rs1_busy", rs1_busy, rs1_addr != 0 && m_pend[rs1_addr]);
            chk("rs2_busy", rs2_busy, rs2_addr != 0 && m_pend[rs2_addr]);
        end
    end

    initial begin
        int got[$];
        int pp[3] = '{30, 90, 10};
        rst_n = 1'b0; idle();
        pipe_rd = '0; pipe_data = '0; ll_iss_rd = '0; ll_rd = '0; ll_data = '0;
        rs1_addr = 5'd1; rs2_addr = 5'd2;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst rf_we", rf_we, 0);
        chk("rst fifo_cnt", fifo_cnt, 0);
        chk("rst ll_ready", ll_ready, 1);
        chk("rst ll_iss_ready", ll_iss_ready, 1);
        chk("rst busy", {rs1_busy, rs2_busy}, 0);
        rst_n = 1'b1; chk_en = 1'b1;

        // Pipe write latency
        pipe_we = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF;
        step(); pipe_we = 1'b0;
        @(negedge clk);
        chk("pipe rf_we", rf_we, 1);
        chk("pipe rf_addr_d", rf_addr_d, 5);
        chk("pipe rf_data_d", rf_data_d, 32'hDEADBEEF);
        step(); @(negedge clk);
        chk("pipe rf_we off", rf_we, 0);

        // Long-latency round trip on rd 7
        step(); ll_iss_valid = 1'b1; ll_iss_rd = 5'd7; rs1_addr = 5'd7;
        step(); ll_iss_valid = 1'b0;
        @(negedge clk); chk("ll7 busy set", rs1_busy, 1);
        step(); ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'h1234;
        step(); ll_valid = 1'b0;
        @(negedge clk); chk("ll7 queued", fifo_cnt, 1);
        step(); @(negedge clk);
        chk("ll7 rf_we", rf_we, 1);
        chk("ll7 rf_addr_d", rf_addr_d, 7);
        chk("ll7 rf_data_d", rf_data_d, 32'h1234);
        chk("ll7 busy held", rs1_busy, 1);
        step(); @(negedge clk);
        chk("ll7 busy clear", rs1_busy, 0);

        // Pipe priority over a queued result
        step(); ll_iss_valid = 1'b1; ll_iss_rd = 5'd3;
        step(); ll_iss_valid = 1'b0; ll_valid = 1'b1; ll_rd = 5'd3; ll_data = 32'h33;
        for (int i = 0; i < 5; i++) begin
            step(); ll_valid = 1'b0;
            pipe_we = (i < 3); pipe_rd = 5'd4; pipe_data = i;
            @(negedge clk);
            chk("prio fifo_cnt", fifo_cnt, (i < 4) ? 1 : 0);
            if (i > 0) chk("prio rf_addr_d", rf_addr_d, (i < 4) ? 4 : 3);
        end
        step(); step();

        // Fill FIFO behind a busy pipe, then drain in order
        pipe_we = 1'b1; pipe_rd = 5'd1;
        for (int i = 0; i < 5; i++) begin
            step(); pipe_data = i; ll_iss_valid = 1'b1; ll_iss_rd = 5'(8 + i);
        end
        step(); ll_iss_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ll_valid = 1'b1; ll_rd = 5'(8 + i); ll_data = 32'(100 + i);
            step();
        end
        ll_rd = 5'd12; ll_data = 32'd104;
        @(negedge clk);
        chk("full cnt", fifo_cnt, 4);
        chk("full ll_ready", ll_ready, 0);
        step(); @(negedge clk);
        chk("full held off", fifo_cnt, 4);
        step(); pipe_we = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 1) ll_valid = 1'b0;
            @(negedge clk);
            if (rf_we && rf_addr_d != 5'd1) got.push_back(int'(rf_addr_d));
        end
        chk("drain count", got.size(), 5);
        for (int i = 0; i < 5 && i < got.size(); i++) chk("drain order", got[i], 8 + i);

        // WAW block, x0 issue and x0 result
        step(); ll_iss_valid = 1'b1; ll_iss_rd = 5'd9;
        step(); @(negedge clk);
        chk("waw refused", ll_iss_ready, 0);
        ll_iss_rd = 5'd0; #1;
        chk("x0 issue ready", ll_iss_ready, 1);
        step(); ll_iss_valid = 1'b0; ll_valid = 1'b1; ll_rd = 5'd0; ll_data = 32'h55;
        step(); ll_valid = 1'b0;
        @(negedge clk);
        chk("x0 result cnt", fifo_cnt, 0);
        chk("x0 result no we", rf_we, 0);
        ll_valid = 1'b1; ll_rd = 5'd9; ll_data = 32'h99;
        step(); ll_valid = 1'b0;
        repeat (4) step();

        // Async reset with queued results and pending bits
        pipe_we = 1'b1; pipe_rd = 5'd1;
        ll_iss_valid = 1'b1; ll_iss_rd = 5'd13; step();
        ll_iss_rd = 5'd14; step();
        ll_iss_valid = 1'b0; ll_valid = 1'b1; ll_rd = 5'd13; step();
        ll_rd = 5'd14; step();
        ll_valid = 1'b0; rs1_addr = 5'd13; rs2_addr = 5'd14;
        #2 rst_n = 1'b0; model_reset();
        #1;
        chk("arst fifo_cnt", fifo_cnt, 0);
        chk("arst busy", {rs1_busy, rs2_busy}, 0);
        chk("arst rf_we", rf_we, 0);
        idle();
        @(negedge clk); @(negedge clk); rst_n = 1'b1;

        // Random traffic in three pipe-load phases
        foreach (pp[p]) begin
            for (int c = 0; c < 1000; c++) begin
                step();
                pipe_rd   = 5'($urandom_range(0, 31));
                pipe_we   = ($urandom_range(0, 99) < pp[p]) && !m_pend[pipe_rd];
                pipe_data = $urandom;
                ll_iss_valid = ($urandom_range(0, 99) < 30);
                ll_iss_rd    = 5'($urandom_range(0, 31));
                ll_data      = $urandom;
                if (infl.size() > 0 && $urandom_range(0, 99) < 50) begin
                    ll_valid = 1'b1;
                    ll_rd    = 5'(infl[$urandom_range(0, infl.size() - 1)]);
                end else if ($urandom_range(0, 99) < 5) begin
                    ll_valid = 1'b1; ll_rd = 5'd0;
                end else begin
                    ll_valid = 1'b0;
                end
                rs1_addr = 5'($urandom_range(0, 31));
                rs2_addr = 5'($urandom_range(0, 31));
            end
        end
        idle();
        repeat (8) step();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
